// File: rtl/max_int64_stream.sv
// Streaming signed-max reducer: one result (max, index, count, overflow) per
// valid/ready packet, built around the gt_int_nbit signed comparator.

module gt_int_nbit #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned IMPL_TYPE = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt_c
);
    generate
        if (IMPL_TYPE == 0) begin : g_signed
            assign gt_c = $signed(a) > $signed(b);
        end else begin : g_bias
            // Flipping the sign bits maps two's complement order onto unsigned order
            assign gt_c = {~a[WIDTH-1], a[WIDTH-2:0]} > {~b[WIDTH-1], b[WIDTH-2:0]};
        end
    endgenerate
endmodule

module max_int64_stream #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned IDX_WIDTH = 16,
    parameter int unsigned IMPL_TYPE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_max,
    output logic [IDX_WIDTH-1:0] out_idx,
    output logic [IDX_WIDTH-1:0] out_count,
    output logic                 out_ovf
);
    typedef enum logic [1:0] {
        S_FIRST = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     max_d;
    logic [IDX_WIDTH-1:0] idx_d, cnt_d;
    logic                 ovf_d;
    logic                 ready_d, valid_d;
    logic                 accept_c;
    logic                 gt_c;

    assign accept_c = in_valid & in_ready;

    gt_int_nbit #(
        .WIDTH    (WIDTH),
        .IMPL_TYPE(IMPL_TYPE)
    ) u_gt (
        .a   (in_data),
        .b   (out_max),
        .gt_c(gt_c)
    );

    // Next-state and running-reduction update
    always_comb begin
        state_d = state_q;
        max_d   = out_max;
        idx_d   = out_idx;
        cnt_d   = out_count;
        ovf_d   = out_ovf;
        case (state_q)
            S_FIRST: begin
                if (accept_c) begin
                    max_d   = in_data;
                    idx_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = in_last ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept_c) begin
                    cnt_d = IDX_WIDTH'(out_count + 1'b1);
                    if (&out_count) begin
                        ovf_d = 1'b1;
                    end
                    // Strictly greater only, so ties keep the earlier index
                    if (gt_c) begin
                        max_d = in_data;
                        idx_d = cnt_d;
                    end
                    if (in_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_valid && out_ready) begin
                    state_d = S_FIRST;
                end
            end
            default: state_d = S_FIRST;
        endcase
        ready_d = (state_d != S_DONE);
        valid_d = (state_d == S_DONE);
    end

    // State, handshake flags and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FIRST;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_max   <= '0;
            out_idx   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= ready_d;
            out_valid <= valid_d;
            out_max   <= max_d;
            out_idx   <= idx_d;
            out_count <= cnt_d;
            out_ovf   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_max_int64_stream.sv
// Bench for max_int64_stream: a default instance and an IDX_WIDTH=2 instance
// share one input stream and are checked against a packet-level reference.

module tb_max_int64_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        rdy_a, vld_a, ovf_a;
    logic [63:0] max_a;
    logic [15:0] idx_a, cnt_a;
    logic        rdy_b, vld_b, ovf_b;
    logic [63:0] max_b;
    logic [1:0]  idx_b, cnt_b;

    int          checks = 0;
    int          passed = 0;
    logic [63:0] pkt[$];

    always #5 clk = ~clk;

    max_int64_stream dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
        .in_data(in_data), .in_last(in_last), .out_valid(vld_a),
        .out_ready(out_ready), .out_max(max_a), .out_idx(idx_a),
        .out_count(cnt_a), .out_ovf(ovf_a)
    );

    max_int64_stream #(.IDX_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
        .in_data(in_data), .in_last(in_last), .out_valid(vld_b),
        .out_ready(out_ready), .out_max(max_b), .out_idx(idx_b),
        .out_count(cnt_b), .out_ovf(ovf_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: first strict signed maximum, index/count reduced mod 2^iw
    task automatic model(input int iw, output logic [63:0] emax, output logic [15:0] eidx,
                         output logic [15:0] ecnt, output logic eovf);
        int n, best;
        n    = pkt.size();
        best = 0;
        for (int i = 1; i < n; i++)
            if ($signed(pkt[i]) > $signed(pkt[best])) best = i;
        emax = pkt[best];
        eidx = 16'(best % (1 << iw));
        ecnt = 16'((n - 1) % (1 << iw));
        eovf = (n > (1 << iw));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid_a"}, 64'(vld_a), 64'd0);
        chk({tag, "_valid_b"}, 64'(vld_b), 64'd0);
        chk({tag, "_ready_a"}, 64'(rdy_a), 64'd1);
        chk({tag, "_ready_b"}, 64'(rdy_b), 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk_idle(tag);
        chk({tag, "_max_a"}, max_a, 64'd0);
        chk({tag, "_idx_a"}, 64'(idx_a), 64'd0);
        chk({tag, "_cnt_a"}, 64'(cnt_a), 64'd0);
        chk({tag, "_ovf_a"}, 64'(ovf_a), 64'd0);
        chk({tag, "_max_b"}, max_b, 64'd0);
        chk({tag, "_ovf_b"}, 64'(ovf_b), 64'd0);
    endtask

    // Drives pkt beat by beat with idle gaps drawn from [gmin, gmax]
    task automatic send(input string tag, input int gmin, input int gmax);
        int n, gap;
        n = pkt.size();
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(gmax, gmin);
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
                in_last  = $urandom_range(1, 0);
                tick();
            end
            in_valid = 1'b1;
            in_data  = pkt[i];
            in_last  = (i == n - 1);
            chk({tag, "_beat_ready"}, 64'(rdy_a & rdy_b), 64'd1);
            if (i == n - 1) chk({tag, "_early_valid"}, 64'(vld_a | vld_b), 64'd0);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_result(input string tag);
        logic [63:0] m;
        logic [15:0] ix, ct;
        logic        ov;
        model(16, m, ix, ct, ov);
        chk({tag, "_valid_a"}, 64'(vld_a), 64'd1);
        chk({tag, "_ready_a"}, 64'(rdy_a), 64'd0);
        chk({tag, "_max_a"}, max_a, m);
        chk({tag, "_idx_a"}, 64'(idx_a), 64'(ix));
        chk({tag, "_cnt_a"}, 64'(cnt_a), 64'(ct));
        chk({tag, "_ovf_a"}, 64'(ovf_a), 64'(ov));
        model(2, m, ix, ct, ov);
        chk({tag, "_valid_b"}, 64'(vld_b), 64'd1);
        chk({tag, "_ready_b"}, 64'(rdy_b), 64'd0);
        chk({tag, "_max_b"}, max_b, m);
        chk({tag, "_idx_b"}, 64'(idx_b), 64'(ix));
        chk({tag, "_cnt_b"}, 64'(cnt_b), 64'(ct));
        chk({tag, "_ovf_b"}, 64'(ovf_b), 64'(ov));
    endtask

    // Checks the result, holds it for 'hold' cycles, then releases it
    task automatic finish_pkt(input string tag, input int hold);
        chk_result(tag);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = $urandom_range(1, 0);
            in_data   = {$urandom, $urandom};
            tick();
            chk_result({tag, "_hold"});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_idle({tag, "_release"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        int          len, sel;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_zero("reset");

        pkt = '{64'd5, -64'sd3, 64'd9, 64'd9};
        send("t1", 0, 0);
        finish_pkt("t1", 0);

        pkt = '{64'h8000_0000_0000_0000};
        send("t2", 0, 0);
        finish_pkt("t2", 1);

        pkt = '{-64'sd1, -64'sd2, 64'h7FFF_FFFF_FFFF_FFFF};
        send("t3", 2, 2);
        finish_pkt("t3", 5);

        pkt = '{64'd10, 64'd20};
        send("t5_partial", 0, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("t5_rst");
        pkt = '{64'd7};
        send("t5", 0, 0);
        finish_pkt("t5", 0);

        pkt = '{64'd3, 64'd1, 64'd2};
        send("done_rst", 0, 1);
        chk_result("done_rst");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("done_rst_after");

        pkt = '{-64'sd8, 64'd1, 64'd0, 64'd1, -64'sd5, 64'd50};
        send("t6", 0, 0);
        finish_pkt("t6", 0);

        pkt = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001};
        send("minval", 0, 1);
        finish_pkt("minval", 0);

        for (int p = 0; p < 40; p++) begin
            pkt = {};
            len = $urandom_range(9, 1);
            v   = '0;
            for (int i = 0; i < len; i++) begin
                sel = $urandom_range(4, 0);
                case (sel)
                    0: v = {$urandom, $urandom};
                    1: v = 64'($signed(32'($urandom_range(8, 0)) - 32'sd4));
                    2: v = 64'h8000_0000_0000_0000;
                    3: v = 64'h7FFF_FFFF_FFFF_FFFF;
                    default: ;
                endcase
                pkt.push_back(v);
            end
            send($sformatf("rnd%0d", p), 0, 2);
            finish_pkt($sformatf("rnd%0d", p), $urandom_range(3, 0));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
